// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the hazard scoreboard: pipeline stage indices and
// the forward-select code, where 0 means "read the register file".
package hazard_scoreboard_pkg;

    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;

    localparam int FWD_RF  = 0;
    localparam int CNT_W   = 16;

    // A hit in stage k is reported as k+1 so that zero stays free for the register file.
    function automatic int fwd_code(input int stage);
        return stage + 1;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-read-port priority match against the tracked stages; purely combinational.
// The youngest (lowest-index) valid producer of the source register wins.
module hazard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int RB         = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int SB         = 2
) (
    input  logic [RB-1:0]       rs_i,
    input  logic                used_i,
    input  logic [DEPTH-1:0]    valid_i,
    input  logic [DEPTH*RB-1:0] rd_i,
    input  logic [DEPTH-1:0]    load_i,
    output logic [SB-1:0]       sel_o,
    output logic                load_hit_o
);

    // Scan oldest to youngest so the last assignment is the youngest hit.
    always_comb begin
        sel_o      = SB'(FWD_RF);
        load_hit_o = 1'b0;
        if (used_i && (rs_i != '0)) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (valid_i[k] && (rd_i[k*RB +: RB] == rs_i)) begin
                    sel_o      = SB'(fwd_code(k));
                    load_hit_o = load_i[k] && (k < LOAD_STAGE);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writers, drives forward selects and load-use stall
// combinationally from state; stall suppresses issue, flush overrides stall.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter  int RB         = 5,
    parameter  int DEPTH      = 3,
    parameter  int NPORT      = 2,
    parameter  int LOAD_STAGE = 1,
    parameter  int FLUSH_N    = 1,
    localparam int SB         = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  logic [RB-1:0]       issue_rd,
    input  logic                issue_regw,
    input  logic                issue_load,
    input  logic [NPORT*RB-1:0] rs_in,
    input  logic [NPORT-1:0]    rs_used,
    input  logic                flush,
    output logic                stall,
    output logic [NPORT*SB-1:0] fwd_sel,
    output logic [CNT_W-1:0]    stall_cnt
);

    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [DEPTH-1:0]    load_q, load_d;
    logic [DEPTH*RB-1:0] rd_q, rd_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [NPORT-1:0]    load_hit;
    logic                issue_trk;

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        hazard_match #(
            .RB         (RB),
            .DEPTH      (DEPTH),
            .LOAD_STAGE (LOAD_STAGE),
            .SB         (SB)
        ) u_match (
            .rs_i       (rs_in[p*RB +: RB]),
            .used_i     (rs_used[p]),
            .valid_i    (valid_q),
            .rd_i       (rd_q),
            .load_i     (load_q),
            .sel_o      (fwd_sel[p*SB +: SB]),
            .load_hit_o (load_hit[p])
        );
    end

    assign stall     = ~flush & (|load_hit);
    assign issue_trk = issue_valid & issue_regw & (issue_rd != '0) & ~stall & ~flush;
    assign stall_cnt = stall_cnt_q;

    // A stalled or flushed decode slot enters EX as a bubble; the rest shift regardless.
    always_comb begin
        valid_d = '0;
        load_d  = '0;
        rd_d    = '0;
        valid_d[STG_EX]            = issue_trk;
        load_d[STG_EX]             = issue_trk & issue_load;
        rd_d[STG_EX*RB +: RB]      = issue_trk ? issue_rd : '0;
        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k]       = valid_q[k-1];
            load_d[k]        = load_q[k-1];
            rd_d[k*RB +: RB] = rd_q[(k-1)*RB +: RB];
        end
        if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (k < FLUSH_N) begin
                    valid_d[k] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= '0;
            load_q      <= '0;
            rd_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            load_q      <= load_d;
            rd_q        <= rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
